// File: rtl/render_pkg.sv
// Shared register map, FSM state encoding and queued sprite-entry layout
// for the sprite command issuer and its renderer-facing Avalon-MM port.
package render_pkg;

  localparam int COORD_W = 18;
  localparam int TEX_W   = 13;

  localparam logic [3:0] REG_MULTI  = 4'd0;
  localparam logic [3:0] REG_COORD  = 4'd1;
  localparam logic [3:0] REG_TEX    = 4'd2;
  localparam logic [3:0] REG_PARITY = 4'd3;
  localparam logic [3:0] REG_GO     = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_SNAP  = 3'd2,
    ST_COORD = 3'd3,
    ST_TEX   = 3'd4,
    ST_GO    = 3'd5,
    ST_GAP   = 3'd6,
    ST_POLL  = 3'd7
  } issuer_state_t;

  typedef struct packed {
    logic               last;
    logic [TEX_W-1:0]   tex;
    logic [COORD_W-1:0] coord;
  } sprite_cmd_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous sprite-command queue; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module sprite_cmd_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  sprite_cmd_t             wdata_i,
  input  logic                    pop_i,
  output sprite_cmd_t             rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  sprite_cmd_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push_s;
  logic        do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sprite_cmd_issuer.sv
// Avalon-MM master that drains queued sprite commands into the renderer
// (coord, tex, GO) and polls the frame-parity register to detect frame end.
module sprite_cmd_issuer
  import render_pkg::*;
#(
  parameter int QDEPTH   = 16,
  parameter int POLL_GAP = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_coord,
  input  logic [TEX_W-1:0]   cmd_tex,
  input  logic               cmd_last,
  input  logic               cfg_write,
  input  logic               cfg_multi,
  output logic [3:0]         m_address,
  output logic               m_write,
  output logic [31:0]        m_writedata,
  output logic               m_read,
  input  logic [31:0]        m_readdata,
  input  logic               m_waitrequest,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  issuer_state_t state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          read_q, read_d;
  logic          rd_wait_q, rd_wait_d;
  sprite_cmd_t   cur_q, cur_d;
  logic          p0_q, p0_d;
  logic          open_q, open_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cfg_pend_q, cfg_pend_d;
  logic          cfg_multi_q, cfg_multi_d;
  logic          done_q, done_d;
  logic [15:0]   fcount_q, fcount_d;

  sprite_cmd_t   head_s;
  logic          full_s, empty_s, push_s, pop_s, cfg_clr_s, parity_s;
  logic [CW-1:0] count_s;
  logic          unused_rd_s;

  assign cmd_ready   = !full_s;
  assign push_s      = cmd_valid && !full_s;
  assign parity_s    = m_readdata[0];
  assign unused_rd_s = ^m_readdata[31:1];

  sprite_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i ({cmd_last, cmd_tex, cmd_coord}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Sequencer: each transfer state loads its strobe, then waits for acceptance.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    read_d    = read_q;
    rd_wait_d = 1'b0;
    cur_d     = cur_q;
    p0_d      = p0_q;
    open_d    = open_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    fcount_d  = fcount_q;
    pop_s     = 1'b0;
    cfg_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_pend_q)    state_d = ST_CFG;
        else if (!empty_s) state_d = open_q ? ST_COORD : ST_SNAP;
        else               state_d = ST_IDLE;
      end
      ST_CFG: begin
        // Pending clears when the value is captured, so a later cfg_write re-arms it.
        if (!write_q) begin
          write_d = 1'b1; addr_d = REG_MULTI; wdata_d = {31'd0, cfg_multi_q}; cfg_clr_s = 1'b1;
        end else if (!m_waitrequest) begin
          write_d = 1'b0; state_d = ST_IDLE;
        end else begin
          write_d = 1'b1;
        end
      end
      ST_SNAP, ST_POLL: begin
        if (rd_wait_q) begin
          if (state_q == ST_SNAP) begin
            p0_d = parity_s; open_d = 1'b1; state_d = ST_COORD;
          end else if (parity_s != p0_q) begin
            done_d = 1'b1; fcount_d = fcount_q + 16'd1; open_d = 1'b0; state_d = ST_IDLE;
          end else begin
            gap_d = '0; state_d = ST_GAP;
          end
        end else if (!read_q) begin
          read_d = 1'b1; addr_d = REG_PARITY;
        end else if (!m_waitrequest) begin
          read_d = 1'b0; rd_wait_d = 1'b1;
        end else begin
          read_d = 1'b1;
        end
      end
      ST_COORD: begin
        if (!write_q) begin
          write_d = 1'b1; addr_d = REG_COORD; cur_d = head_s; pop_s = 1'b1;
          wdata_d = {{(32-COORD_W){1'b0}}, head_s.coord};
        end else if (!m_waitrequest) begin
          write_d = 1'b0; state_d = ST_TEX;
        end else begin
          write_d = 1'b1;
        end
      end
      ST_TEX: begin
        if (!write_q) begin
          write_d = 1'b1; addr_d = REG_TEX; wdata_d = {{(32-TEX_W){1'b0}}, cur_q.tex};
        end else if (!m_waitrequest) begin
          write_d = 1'b0; state_d = ST_GO;
        end else begin
          write_d = 1'b1;
        end
      end
      ST_GO: begin
        if (!write_q) begin
          write_d = 1'b1; addr_d = REG_GO; wdata_d = 32'd0;
        end else if (!m_waitrequest) begin
          write_d = 1'b0; gap_d = '0; state_d = cur_q.last ? ST_GAP : ST_IDLE;
        end else begin
          write_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0; state_d = ST_POLL;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_multi_d = cfg_write ? cfg_multi : cfg_multi_q;
    if (cfg_write)      cfg_pend_d = 1'b1;
    else if (cfg_clr_s) cfg_pend_d = 1'b0;
    else                cfg_pend_d = cfg_pend_q;
  end

  // State and registered Avalon outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE; addr_q <= 4'd0; wdata_q <= 32'd0; write_q <= 1'b0;
      read_q <= 1'b0; rd_wait_q <= 1'b0; cur_q <= '0; p0_q <= 1'b0; open_q <= 1'b0;
      gap_q <= '0; cfg_pend_q <= 1'b0; cfg_multi_q <= 1'b0; done_q <= 1'b0; fcount_q <= 16'd0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; wdata_q <= wdata_d; write_q <= write_d;
      read_q <= read_d; rd_wait_q <= rd_wait_d; cur_q <= cur_d; p0_q <= p0_d; open_q <= open_d;
      gap_q <= gap_d; cfg_pend_q <= cfg_pend_d; cfg_multi_q <= cfg_multi_d; done_q <= done_d;
      fcount_q <= fcount_d;
    end
  end

  assign m_address   = addr_q;
  assign m_write     = write_q;
  assign m_writedata = wdata_q;
  assign m_read      = read_q;
  assign frame_done  = done_q;
  assign frame_count = fcount_q;
  assign busy        = (state_q != ST_IDLE) || (count_s != '0);

endmodule
